// File: rtl/mem_bus_pkg.sv
// Shared constants, state encoding and nibble helpers for the memory bus arbiter.
package mem_bus_pkg;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned MAX_NIB = 3;
    localparam int unsigned DATA_W  = MAX_NIB * NIB_W;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_LDR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_D = 2'd2,
        DONE = 2'd3
    } state_t;

    // Effective nibble count: a length of zero moves one nibble.
    function automatic logic [1:0] eff_len(input logic [1:0] len);
        return (len == 2'd0) ? 2'd1 : len;
    endfunction

    // Extract nibble idx of a transaction word.
    function automatic logic [NIB_W-1:0] nib_get(input logic [DATA_W-1:0] d,
                                                 input logic [1:0]        idx);
        logic [NIB_W-1:0] r;
        case (idx)
            2'd0:    r = d[0*NIB_W +: NIB_W];
            2'd1:    r = d[1*NIB_W +: NIB_W];
            2'd2:    r = d[2*NIB_W +: NIB_W];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Replace nibble idx of a transaction word.
    function automatic logic [DATA_W-1:0] nib_set(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        idx,
                                                  input logic [NIB_W-1:0]  nib);
        logic [DATA_W-1:0] r;
        r = d;
        case (idx)
            2'd0:    r[0*NIB_W +: NIB_W] = nib;
            2'd1:    r[1*NIB_W +: NIB_W] = nib;
            2'd2:    r[2*NIB_W +: NIB_W] = nib;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker; combinational, pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick_c
);

    // On contention favour the port that was not granted last.
    always_comb begin
        pick_c = 2'b00;
        if (req == 2'b11) begin
            pick_c = last ? 2'b01 : 2'b10;
        end else begin
            pick_c = req;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the nibble-wide memory bus between the CPU and the loader port;
// each grant moves 1-3 consecutive nibbles and is never preempted.
module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [11:0]       addr0,
    input  logic [11:0]       addr1,
    input  logic [1:0]        len0,
    input  logic [1:0]        len1,
    input  logic [11:0]       wdata0,
    input  logic [11:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [11:0]       rdata0,
    output logic [11:0]       rdata1,
    output logic [11:0]       bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wdata,
    input  logic [3:0]        bus_rdata
);

    state_t              state, state_d;
    logic                sel, sel_d;
    logic                we_l, we_l_d;
    logic [ADDR_W-1:0]   addr_l, addr_l_d;
    logic [1:0]          n_l, n_l_d;
    logic [DATA_W-1:0]   wdata_l, wdata_l_d;
    logic [1:0]          k, k_d;
    logic                last, last_d;

    logic                gnt0_d, gnt1_d, done0_d, done1_d;
    logic [DATA_W-1:0]   rdata0_d, rdata1_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic                bus_we_d;
    logic [NIB_W-1:0]    bus_wdata_d;

    logic [1:0]          pick;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [1:0]          win_len;
    logic [DATA_W-1:0]   win_wdata;
    logic [1:0]          k_nxt;

    rr_arb2 u_rr_arb2 (
        .req    ({req1, req0}),
        .last   (last),
        .pick_c (pick)
    );

    // Request fields of the port the picker selected.
    always_comb begin
        win_we    = pick[PORT_LDR] ? we1    : we0;
        win_addr  = pick[PORT_LDR] ? addr1  : addr0;
        win_len   = eff_len(pick[PORT_LDR] ? len1 : len0);
        win_wdata = pick[PORT_LDR] ? wdata1 : wdata0;
        k_nxt     = k + 2'd1;
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        we_l_d      = we_l;
        addr_l_d    = addr_l;
        n_l_d       = n_l;
        wdata_l_d   = wdata_l;
        k_d         = k;
        last_d      = last;
        gnt0_d      = gnt0;
        gnt1_d      = gnt1;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;
        bus_addr_d  = bus_addr;
        bus_we_d    = 1'b0;
        bus_wdata_d = '0;

        case (state)
            IDLE: begin
                if (pick != 2'b00) begin
                    state_d    = PH_A;
                    sel_d      = pick[PORT_LDR];
                    we_l_d     = win_we;
                    addr_l_d   = win_addr;
                    n_l_d      = win_len;
                    wdata_l_d  = win_wdata;
                    k_d        = 2'd0;
                    gnt0_d     = pick[PORT_CPU];
                    gnt1_d     = pick[PORT_LDR];
                    bus_addr_d = win_addr;
                    bus_we_d   = win_we;
                    if (win_we) begin
                        bus_wdata_d = nib_get(win_wdata, 2'd0);
                    end else if (pick[PORT_LDR]) begin
                        rdata1_d = '0;
                    end else begin
                        rdata0_d = '0;
                    end
                end
            end
            PH_A: begin
                state_d = PH_D;
            end
            PH_D: begin
                if (!we_l) begin
                    if (sel) rdata1_d = nib_set(rdata1, k, bus_rdata);
                    else     rdata0_d = nib_set(rdata0, k, bus_rdata);
                end
                if (k == n_l - 2'd1) begin
                    state_d = DONE;
                    done0_d = ~sel;
                    done1_d = sel;
                end else begin
                    state_d    = PH_A;
                    k_d        = k_nxt;
                    bus_addr_d = addr_l + ADDR_W'(k_nxt);
                    bus_we_d   = we_l;
                    if (we_l) bus_wdata_d = nib_get(wdata_l, k_nxt);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                last_d  = sel;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            we_l      <= 1'b0;
            addr_l    <= '0;
            n_l       <= 2'd1;
            wdata_l   <= '0;
            k         <= 2'd0;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            we_l      <= we_l_d;
            addr_l    <= addr_l_d;
            n_l       <= n_l_d;
            wdata_l   <= wdata_l_d;
            k         <= k_d;
            last      <= last_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
            bus_addr  <= bus_addr_d;
            bus_we    <= bus_we_d;
            bus_wdata <= bus_wdata_d;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single nibble-wide memory bus (12-bit address, 4-bit data) between two requesters:
  - port 0: CPU core, for instruction fetch and load/store.
  - port 1: program loader/debug port.
- Each granted transaction moves 1-3 consecutive nibbles, so the CPU fetches a 12-bit instruction as one request.
- Round-robin arbitration; a granted transaction is never preempted.
- Sits between the CPU/loader and the external memory; it owns bus_addr and bus write control.

Parameters:
- ADDR_W, 12, bus address width.
- NIB_W, 4, bus data width (one nibble).
- MAX_NIB, 3, maximum nibbles per transaction; sets the width of wdata/rdata (MAX_NIB*NIB_W).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1.
- we0 / we1  in  1  1 = write transaction, 0 = read.
- addr0 / addr1  in  12  start address.
- len0 / len1  in  2  nibble count; 1..3, with 0 treated as 1.
- wdata0 / wdata1  in  12  write data; nibble i is bits [4i+3:4i].
- gnt0 / gnt1  out  1  high while that port's transaction owns the bus.
- done0 / done1  out  1  one-cycle completion pulse.
- rdata0 / rdata1  out  12  read data; unread nibbles are zero.
- bus_addr  out  12  memory address.
- bus_we  out  1  memory write strobe.
- bus_wdata  out  4  memory write data.
- bus_rdata  in  4  memory read data, valid the cycle after the address is presented.

Behaviour:
- Reset values: all outputs 0; round-robin pointer favours port 0; state IDLE.
- Reset mid-transaction aborts it: no done, no further bus_we, all outputs return to reset values next cycle.
- States: IDLE, PH_A, PH_D, DONE.
- IDLE:
  - Samples req0/req1.
  - If any request is present, latch the winner's we/addr/len/wdata, set nibble index k=0, go to PH_A.
  - Winner rule when both request: the port not granted last. First contention after reset goes to port 0.
  - A single requester always wins.
- PH_A (nibble k):
  - bus_addr = start+k, modulo 2^12 (0xFFF wraps to 0x000).
  - For writes: bus_we=1 and bus_wdata = nibble k, for this one cycle only.
  - Go to PH_D.
- PH_D:
  - bus_we=0; bus_addr held.
  - For reads: capture bus_rdata into nibble k of the winner's rdata.
  - If k = n-1 go to DONE, else k++ and go to PH_A.
- DONE:
  - done of the winner = 1 for exactly one cycle; gnt drops after this cycle.
  - Round-robin pointer updates to the winner; go to IDLE.
- gnt of the winner is high from the first PH_A through DONE inclusive. gnt0 and gnt1 are never both high.
- Latency: with req seen in IDLE at cycle t, the first PH_A is t+1 and done is at t+1+2n.
- Per-port minimum turnaround is 2n+2 cycles.
- Requester rules:
  - Hold req and request fields stable until done.
  - req in the cycle after done means a new request.
- Request fields are latched in IDLE; changes during a transaction are ignored.
- Dropping req mid-transaction does not abort the transaction.
- rdata:
  - Cleared to 0 at the start of a read on that port.
  - Valid when done is high; held until that port's next read.
  - Writes leave rdata unchanged.
- Bus idle values (IDLE/DONE): bus_we=0, bus_wdata=0, bus_addr holds its last value.
- All outputs are registered; there is no combinational path from req to bus.

Decomposition:
- Package mem_bus_pkg:
  - ADDR_W, NIB_W, MAX_NIB.
  - State encoding for IDLE/PH_A/PH_D/DONE.
  - Port index constants PORT_CPU=0, PORT_LDR=1.
- One sub-module, rr_arb2: 2-way round-robin picker (req[1:0] and last-grant pointer in; one-hot pick out). It is combinational; the pointer register lives in the parent.

Test Plan:
- Single read: req0, we0=0, addr0=0x010, len0=3, memory holds 0x010=A, 0x011=B, 0x012=C.
  - Expect bus_addr 0x010/0x011/0x012 in successive PH_A cycles.
  - Expect done0 at t+7 with rdata0=0xCBA.
- Write with wrap: req1, we1=1, addr1=0xFFF, len1=2, wdata1=0x05A.
  - Expect bus_we high for one cycle at 0xFFF with data A, then at 0x000 with data 5.
  - Expect done1 at t+5 with rdata1 unchanged.
- Contention: req0 and req1 raised in the same cycle after reset, both len=1, both held across done.
  - Expect order port 0, port 1, port 0, strictly alternating.
  - Expect gnt0 and gnt1 never high together.
- len=0: addr0=0x100, len0=0.
  - Expect one nibble transferred and done0 at t+3.
- Reset asserted during PH_D of nibble 1 of a 3-nibble write.
  - Expect no further bus_we, no done, all outputs 0 the next cycle.
  - A subsequent req1 is granted normally.
- Field change mid-transaction: change addr0 and drop req0 during PH_A.
  - Expect the original addresses to complete and done0 to pulse; no new transaction follows.
